// File: rtl/pc_seq_pkg.sv
// Shared encodings for the fetch-stage PC sequencer: decoded ops, FSM states
// and fault codes.
package pc_seq_pkg;

    localparam int PC_W = 16;

    typedef enum logic [2:0] {
        OP_SEQ  = 3'd0,
        OP_JMP  = 3'd1,
        OP_BRZ  = 3'd2,
        OP_CALL = 3'd3,
        OP_RET  = 3'd4,
        OP_HALT = 3'd5
    } op_e;

    typedef enum logic [2:0] {
        BOOT,
        RUN,
        BUBBLE,
        HALT,
        FAULT
    } state_e;

    typedef enum logic [1:0] {
        FC_NONE      = 2'd0,
        FC_OVERFLOW  = 2'd1,
        FC_UNDERFLOW = 2'd2
    } fault_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Decoder/fetch-side bundle of the PC sequencer. The master drives the decoded
// op and control inputs; the slave (the sequencer) returns the fetch address
// and status.
interface pc_sequencer_if #(
    parameter int RS_DEPTH = 8
);
    localparam int DEPTH_W = $clog2(RS_DEPTH) + 1;

    logic [15:0]        pc_reset_address;
    logic               stall;
    logic               op_valid;
    logic [2:0]         op;
    logic [15:0]        target;
    logic               cond;
    logic               resume;

    logic [15:0]        pc;
    logic               fetch_valid;
    logic               halted;
    logic               fault;
    logic [1:0]         fault_code;
    logic [DEPTH_W-1:0] rs_depth;

    modport master (
        output pc_reset_address, stall, op_valid, op, target, cond, resume,
        input  pc, fetch_valid, halted, fault, fault_code, rs_depth
    );

    modport slave (
        input  pc_reset_address, stall, op_valid, op, target, cond, resume,
        output pc, fetch_valid, halted, fault, fault_code, rs_depth
    );

endinterface

// File: rtl/return_stack.sv
// Hardware return-address stack: register array plus occupancy counter.
// rdata always shows the top entry; push when full and pop when empty are ignored.
module return_stack #(
    parameter int RS_DEPTH = 8,
    parameter int DATA_W   = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic                      pop,
    input  logic [DATA_W-1:0]         wdata,
    output logic [DATA_W-1:0]         rdata,
    output logic [$clog2(RS_DEPTH):0] depth,
    output logic                      full,
    output logic                      empty
);
    localparam int AW = $clog2(RS_DEPTH);
    localparam int DW = AW + 1;

    logic [DATA_W-1:0] mem [RS_DEPTH];
    logic [AW-1:0]     wr_idx;
    logic [AW-1:0]     top_idx;

    assign wr_idx  = depth[AW-1:0];
    assign top_idx = AW'(depth - DW'(1));
    assign full    = (depth == DW'(RS_DEPTH));
    assign empty   = (depth == '0);
    assign rdata   = mem[top_idx];

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            depth <= '0;
        end else if (push && !full) begin
            depth <= depth + DW'(1);
        end else if (pop && !empty) begin
            depth <= depth - DW'(1);
        end
    end

    // NOTE: the entry array is deliberately not reset; depth alone defines
    // which entries are meaningful, and leaving it out keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_idx] <= wdata;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: FSM, next-PC mux and PC register, with a
// return-address stack for CALL/RET and sticky stack-fault reporting.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int RS_DEPTH = 8,
    parameter int PC_INC   = 1
) (
    input logic           clk,
    input logic           reset,
    pc_sequencer_if.slave bus
);
    localparam int DW = $clog2(RS_DEPTH) + 1;

    state_e            state, state_n;
    fault_e            fc_q, fc_n;
    logic [PC_W-1:0]   pc_q, pc_n, pc_inc;
    logic              fv_q, halted_q, fault_q;
    logic              push, pop;
    logic [PC_W-1:0]   rs_rdata;
    logic [DW-1:0]     rs_depth;
    logic              rs_full, rs_empty;

    // Wraps modulo 2^16; also serves as the CALL return address.
    assign pc_inc = pc_q + PC_W'(PC_INC);

    return_stack #(
        .RS_DEPTH (RS_DEPTH),
        .DATA_W   (PC_W)
    ) u_rs (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (pc_inc),
        .rdata (rs_rdata),
        .depth (rs_depth),
        .full  (rs_full),
        .empty (rs_empty)
    );

    // NOTE: every signal gets a default before any branch so no path leaves
    // it unassigned, which would infer a latch.
    always_comb begin
        state_n = state;
        pc_n    = pc_q;
        fc_n    = fc_q;
        push    = 1'b0;
        pop     = 1'b0;
        if (!bus.stall) begin
            unique case (state)
                BOOT:   state_n = RUN;
                BUBBLE: state_n = RUN;
                HALT:   if (bus.resume) state_n = RUN;
                FAULT:  ;
                RUN: begin
                    if (bus.op_valid) begin
                        case (op_e'(bus.op))
                            OP_JMP: begin
                                pc_n    = bus.target;
                                state_n = BUBBLE;
                            end
                            OP_BRZ: begin
                                if (bus.cond) begin
                                    pc_n    = bus.target;
                                    state_n = BUBBLE;
                                end else begin
                                    pc_n = pc_inc;
                                end
                            end
                            OP_CALL: begin
                                if (rs_full) begin
                                    fc_n    = FC_OVERFLOW;
                                    state_n = FAULT;
                                end else begin
                                    push    = 1'b1;
                                    pc_n    = bus.target;
                                    state_n = BUBBLE;
                                end
                            end
                            OP_RET: begin
                                if (rs_empty) begin
                                    fc_n    = FC_UNDERFLOW;
                                    state_n = FAULT;
                                end else begin
                                    pop     = 1'b1;
                                    pc_n    = rs_rdata;
                                    state_n = BUBBLE;
                                end
                            end
                            OP_HALT: begin
                                pc_n    = pc_inc;
                                state_n = HALT;
                            end
                            default: pc_n = pc_inc;
                        endcase
                    end
                end
                default: state_n = state;
            endcase
        end
    end

    // Status flags are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= BOOT;
            pc_q     <= bus.pc_reset_address;
            fc_q     <= FC_NONE;
            fv_q     <= 1'b0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state    <= state_n;
            pc_q     <= pc_n;
            fc_q     <= fc_n;
            fv_q     <= (state_n == RUN);
            halted_q <= (state_n == HALT);
            fault_q  <= (state_n == FAULT);
        end
    end

    assign bus.pc          = pc_q;
    assign bus.fetch_valid = fv_q;
    assign bus.halted      = halted_q;
    assign bus.fault       = fault_q;
    assign bus.fault_code  = fc_q;
    assign bus.rs_depth    = rs_depth;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a vector table plus hand-written
// overflow/underflow/reset sequences, all checked through an expected-value queue.
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    logic clk;
    logic reset;

    pc_sequencer_if #(.RS_DEPTH(8)) bus ();

    pc_sequencer #(
        .RS_DEPTH (8),
        .PC_INC   (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] pc;
        logic        fv;
        logic        halted;
        logic        fault;
        logic [1:0]  fc;
        logic [3:0]  depth;
    } exp_t;

    typedef struct packed {
        logic        stall;
        logic        ov;
        logic [2:0]  op;
        logic [15:0] tgt;
        logic        cond;
        logic        resume;
        exp_t        e;
    } vec_t;

    exp_t sb_q[$];
    vec_t tbl[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    function automatic exp_t mk_exp(logic [15:0] pc, logic fv, logic h, logic f,
                                    logic [1:0] fc, logic [3:0] d);
        exp_t e;
        e.pc = pc; e.fv = fv; e.halted = h; e.fault = f; e.fc = fc; e.depth = d;
        return e;
    endfunction

    task automatic add(input logic s, input logic ov, input logic [2:0] op,
                       input logic [15:0] tgt, input logic c, input logic r,
                       input logic [15:0] pc, input logic fv, input logic h,
                       input logic [3:0] d);
        vec_t v;
        v.stall = s; v.ov = ov; v.op = op; v.tgt = tgt; v.cond = c; v.resume = r;
        v.e = mk_exp(pc, fv, h, 1'b0, 2'd0, d);
        tbl.push_back(v);
    endtask

    // Drive one cycle of inputs, queue the expectation, compare after the edge.
    task automatic apply(input string tag, input logic rst, input logic s, input logic ov,
                         input logic [2:0] op, input logic [15:0] tgt, input logic c,
                         input logic r, input exp_t e);
        exp_t got;
        reset        = rst;
        bus.stall    = s;
        bus.op_valid = ov;
        bus.op       = op;
        bus.target   = tgt;
        bus.cond     = c;
        bus.resume   = r;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check({tag, " scoreboard"}, 32'd0, 32'd1);
        end else begin
            got = sb_q.pop_front();
            check({tag, " pc"},          {16'd0, bus.pc},          {16'd0, got.pc});
            check({tag, " fetch_valid"}, {31'd0, bus.fetch_valid}, {31'd0, got.fv});
            check({tag, " halted"},      {31'd0, bus.halted},      {31'd0, got.halted});
            check({tag, " fault"},       {31'd0, bus.fault},       {31'd0, got.fault});
            check({tag, " fault_code"},  {30'd0, bus.fault_code},  {30'd0, got.fc});
            check({tag, " rs_depth"},    {28'd0, bus.rs_depth},    {28'd0, got.depth});
        end
    endtask

    task automatic idle_exp(input string tag, input logic rst, input exp_t e);
        apply(tag, rst, 1'b0, 1'b0, OP_SEQ, 16'h0000, 1'b0, 1'b0, e);
    endtask

    // Two reset cycles (BOOT state) then release: BOOT->RUN leaves pc unchanged.
    task automatic do_reset(input string tag, input logic [15:0] addr);
        bus.pc_reset_address = addr;
        idle_exp({tag, " rst0"}, 1'b1, mk_exp(addr, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0));
        idle_exp({tag, " rst1"}, 1'b1, mk_exp(addr, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0));
        idle_exp({tag, " boot"}, 1'b0, mk_exp(addr, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        bus.pc_reset_address = 16'h0100;
        bus.stall = 1'b0; bus.op_valid = 1'b0; bus.op = OP_SEQ;
        bus.target = 16'h0; bus.cond = 1'b0; bus.resume = 1'b0;

        // stall ov op      target    c     r     pc        fv    h     depth
        for (int i = 1; i <= 5; i++)
            add(1'b0, 1'b1, OP_SEQ, 16'h0000, 1'b0, 1'b0, 16'h0100 + 16'(i), 1'b1, 1'b0, 4'd0);
        add(1'b0, 1'b1, OP_JMP,  16'h0200, 1'b0, 1'b0, 16'h0200, 1'b0, 1'b0, 4'd0);
        add(1'b0, 1'b0, OP_SEQ,  16'h0000, 1'b0, 1'b0, 16'h0200, 1'b1, 1'b0, 4'd0);
        add(1'b0, 1'b1, OP_BRZ,  16'h0300, 1'b0, 1'b0, 16'h0201, 1'b1, 1'b0, 4'd0);
        add(1'b0, 1'b1, OP_BRZ,  16'h0300, 1'b1, 1'b0, 16'h0300, 1'b0, 1'b0, 4'd0);
        add(1'b0, 1'b0, OP_SEQ,  16'h0000, 1'b0, 1'b0, 16'h0300, 1'b1, 1'b0, 4'd0);
        add(1'b0, 1'b0, OP_JMP,  16'h0999, 1'b0, 1'b0, 16'h0300, 1'b1, 1'b0, 4'd0);
        add(1'b0, 1'b1, 3'd6,    16'h0999, 1'b0, 1'b0, 16'h0301, 1'b1, 1'b0, 4'd0);
        add(1'b0, 1'b1, 3'd7,    16'h0999, 1'b0, 1'b0, 16'h0302, 1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 3; i++)
            add(1'b1, 1'b1, OP_JMP, 16'h0500, 1'b0, 1'b0, 16'h0302, 1'b1, 1'b0, 4'd0);
        add(1'b1, 1'b1, OP_CALL, 16'h0500, 1'b0, 1'b0, 16'h0302, 1'b1, 1'b0, 4'd0);
        add(1'b0, 1'b1, OP_JMP,  16'h0010, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0, 4'd0);
        add(1'b0, 1'b0, OP_SEQ,  16'h0000, 1'b0, 1'b0, 16'h0010, 1'b1, 1'b0, 4'd0);
        add(1'b0, 1'b1, OP_CALL, 16'h0400, 1'b0, 1'b0, 16'h0400, 1'b0, 1'b0, 4'd1);
        add(1'b0, 1'b0, OP_SEQ,  16'h0000, 1'b0, 1'b0, 16'h0400, 1'b1, 1'b0, 4'd1);
        add(1'b0, 1'b1, OP_SEQ,  16'h0000, 1'b0, 1'b0, 16'h0401, 1'b1, 1'b0, 4'd1);
        add(1'b0, 1'b1, OP_SEQ,  16'h0000, 1'b0, 1'b0, 16'h0402, 1'b1, 1'b0, 4'd1);
        add(1'b1, 1'b1, OP_RET,  16'h0000, 1'b0, 1'b0, 16'h0402, 1'b1, 1'b0, 4'd1);
        add(1'b0, 1'b1, OP_RET,  16'h0000, 1'b0, 1'b0, 16'h0011, 1'b0, 1'b0, 4'd0);
        add(1'b0, 1'b0, OP_SEQ,  16'h0000, 1'b0, 1'b0, 16'h0011, 1'b1, 1'b0, 4'd0);
        // three-deep nesting, unwound in LIFO order
        add(1'b0, 1'b1, OP_CALL, 16'h0500, 1'b0, 1'b0, 16'h0500, 1'b0, 1'b0, 4'd1);
        add(1'b0, 1'b0, OP_SEQ,  16'h0000, 1'b0, 1'b0, 16'h0500, 1'b1, 1'b0, 4'd1);
        add(1'b0, 1'b1, OP_CALL, 16'h0600, 1'b0, 1'b0, 16'h0600, 1'b0, 1'b0, 4'd2);
        add(1'b0, 1'b0, OP_SEQ,  16'h0000, 1'b0, 1'b0, 16'h0600, 1'b1, 1'b0, 4'd2);
        add(1'b0, 1'b1, OP_CALL, 16'h0700, 1'b0, 1'b0, 16'h0700, 1'b0, 1'b0, 4'd3);
        add(1'b0, 1'b0, OP_SEQ,  16'h0000, 1'b0, 1'b0, 16'h0700, 1'b1, 1'b0, 4'd3);
        add(1'b0, 1'b1, OP_RET,  16'h0000, 1'b0, 1'b0, 16'h0601, 1'b0, 1'b0, 4'd2);
        add(1'b0, 1'b0, OP_SEQ,  16'h0000, 1'b0, 1'b0, 16'h0601, 1'b1, 1'b0, 4'd2);
        add(1'b0, 1'b1, OP_RET,  16'h0000, 1'b0, 1'b0, 16'h0501, 1'b0, 1'b0, 4'd1);
        add(1'b0, 1'b0, OP_SEQ,  16'h0000, 1'b0, 1'b0, 16'h0501, 1'b1, 1'b0, 4'd1);
        add(1'b0, 1'b1, OP_RET,  16'h0000, 1'b0, 1'b0, 16'h0012, 1'b0, 1'b0, 4'd0);
        add(1'b0, 1'b0, OP_SEQ,  16'h0000, 1'b0, 1'b0, 16'h0012, 1'b1, 1'b0, 4'd0);
        // op offered during BUBBLE is not accepted
        add(1'b0, 1'b1, OP_JMP,  16'h0040, 1'b0, 1'b0, 16'h0040, 1'b0, 1'b0, 4'd0);
        add(1'b0, 1'b1, OP_SEQ,  16'h0000, 1'b0, 1'b0, 16'h0040, 1'b1, 1'b0, 4'd0);
        // stall holds BUBBLE, then HALT wraps 0xFFFF -> 0x0000
        add(1'b0, 1'b1, OP_JMP,  16'hFFFF, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 4'd0);
        add(1'b1, 1'b0, OP_SEQ,  16'h0000, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 4'd0);
        add(1'b0, 1'b0, OP_SEQ,  16'h0000, 1'b0, 1'b0, 16'hFFFF, 1'b1, 1'b0, 4'd0);
        add(1'b0, 1'b1, OP_HALT, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 4'd0);
        add(1'b0, 1'b1, OP_JMP,  16'h0777, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 4'd0);
        add(1'b1, 1'b0, OP_SEQ,  16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 4'd0);
        add(1'b0, 1'b0, OP_SEQ,  16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 4'd0);
        add(1'b0, 1'b1, OP_SEQ,  16'h0000, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0, 4'd0);
        add(1'b0, 1'b1, OP_SEQ,  16'h0000, 1'b0, 1'b0, 16'h0002, 1'b1, 1'b0, 4'd0);
        // pushed return address wraps too
        add(1'b0, 1'b1, OP_JMP,  16'hFFFF, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 4'd0);
        add(1'b0, 1'b0, OP_SEQ,  16'h0000, 1'b0, 1'b0, 16'hFFFF, 1'b1, 1'b0, 4'd0);
        add(1'b0, 1'b1, OP_CALL, 16'h0080, 1'b0, 1'b0, 16'h0080, 1'b0, 1'b0, 4'd1);
        add(1'b0, 1'b0, OP_SEQ,  16'h0000, 1'b0, 1'b0, 16'h0080, 1'b1, 1'b0, 4'd1);
        add(1'b0, 1'b1, OP_RET,  16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'd0);
        add(1'b0, 1'b0, OP_SEQ,  16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4'd0);

        do_reset("boot", 16'h0100);
        foreach (tbl[i]) begin
            apply($sformatf("vec%0d", i), 1'b0, tbl[i].stall, tbl[i].ov, tbl[i].op,
                  tbl[i].tgt, tbl[i].cond, tbl[i].resume, tbl[i].e);
        end

        // Overflow: eight CALLs fill the stack, the ninth faults with pc held.
        do_reset("ovf", 16'h0020);
        for (int k = 1; k <= 8; k++) begin
            apply($sformatf("call%0d", k), 1'b0, 1'b0, 1'b1, OP_CALL,
                  16'h1000 + 16'((k - 1) * 16), 1'b0, 1'b0,
                  mk_exp(16'h1000 + 16'((k - 1) * 16), 1'b0, 1'b0, 1'b0, 2'd0, 4'(k)));
            idle_exp($sformatf("call%0d idle", k), 1'b0,
                     mk_exp(16'h1000 + 16'((k - 1) * 16), 1'b1, 1'b0, 1'b0, 2'd0, 4'(k)));
        end
        apply("call9", 1'b0, 1'b0, 1'b1, OP_CALL, 16'h2000, 1'b0, 1'b0,
              mk_exp(16'h1070, 1'b0, 1'b0, 1'b1, 2'd1, 4'd8));
        apply("fault hold", 1'b0, 1'b0, 1'b1, OP_JMP, 16'h3000, 1'b0, 1'b1,
              mk_exp(16'h1070, 1'b0, 1'b0, 1'b1, 2'd1, 4'd8));
        apply("fault stall", 1'b0, 1'b1, 1'b1, OP_RET, 16'h0000, 1'b0, 1'b1,
              mk_exp(16'h1070, 1'b0, 1'b0, 1'b1, 2'd1, 4'd8));

        // Underflow: RET straight after reset.
        do_reset("unf", 16'h0040);
        apply("ret empty", 1'b0, 1'b0, 1'b1, OP_RET, 16'h0000, 1'b0, 1'b0,
              mk_exp(16'h0040, 1'b0, 1'b0, 1'b1, 2'd2, 4'd0));
        idle_exp("unf hold", 1'b0, mk_exp(16'h0040, 1'b0, 1'b0, 1'b1, 2'd2, 4'd0));

        // Reset on the same edge as a CALL: no push, back to BOOT.
        do_reset("mid", 16'h0050);
        bus.pc_reset_address = 16'h0300;
        apply("rst+call", 1'b1, 1'b0, 1'b1, OP_CALL, 16'h0900, 1'b0, 1'b0,
              mk_exp(16'h0300, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0));
        idle_exp("rst+call boot", 1'b0, mk_exp(16'h0300, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0));
        apply("rst+call ret", 1'b0, 1'b0, 1'b1, OP_RET, 16'h0000, 1'b0, 1'b0,
              mk_exp(16'h0300, 1'b0, 1'b0, 1'b1, 2'd2, 4'd0));
        // Reset during stall while faulted still wins.
        apply("rst+stall", 1'b1, 1'b1, 1'b1, OP_SEQ, 16'h0000, 1'b0, 1'b0,
              mk_exp(16'h0300, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0));

        check("scoreboard drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
